// File: rtl/regex_cpu_window.sv
// Single-thread regex step over a character window: fetch (pc), execute against window[cc_id], emit 0..2 successors.
// Four cycles from thread acceptance to first output; outputs hold while output_pc_ready=0; REGEX_CPU_WINDOW_EXT_OPCODES_EN enables MATCH_ANY/NOT_MATCH.
module regex_cpu_window #(
    parameter int PC_WIDTH          = 8,
    parameter int CHARACTER_WIDTH   = 8,
    parameter int CC_ID_BITS        = 2,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]  current_characters,
    input  logic                                        input_pc_valid,
    output logic                                        input_pc_ready,
    input  logic [PC_WIDTH-1:0]                         input_pc,
    input  logic [CC_ID_BITS-1:0]                       input_cc_id,
    output logic                                        memory_valid,
    input  logic                                        memory_ready,
    output logic [MEMORY_ADDR_WIDTH-1:0]                memory_addr,
    input  logic [MEMORY_WIDTH-1:0]                     memory_data,
    output logic                                        output_pc_valid,
    input  logic                                        output_pc_ready,
    output logic [PC_WIDTH-1:0]                         output_pc,
    output logic [CC_ID_BITS-1:0]                       output_cc_id,
    output logic                                        accepts
);

    localparam int WINDOW_BITS = (2**CC_ID_BITS) * CHARACTER_WIDTH;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT_DATA = 3'd2;
    localparam logic [2:0] S_EXEC      = 3'd3;
    localparam logic [2:0] S_OUT_A     = 3'd4;
    localparam logic [2:0] S_OUT_B     = 3'd5;

    localparam logic [2:0] OP_ACCEPT         = 3'd0;
    localparam logic [2:0] OP_SPLIT          = 3'd1;
    localparam logic [2:0] OP_MATCH          = 3'd2;
    localparam logic [2:0] OP_JMP            = 3'd3;
    localparam logic [2:0] OP_END            = 3'd4;
    localparam logic [2:0] OP_MATCH_ANY      = 3'd5;
    localparam logic [2:0] OP_ACCEPT_PARTIAL = 3'd6;
    localparam logic [2:0] OP_NOT_MATCH      = 3'd7;

    logic [2:0]                 state;
    logic [PC_WIDTH-1:0]        pc_q;
    logic [CC_ID_BITS-1:0]      cc_q;
    logic [WINDOW_BITS-1:0]     window_q;
    logic [MEMORY_WIDTH-1:0]    instr_q;
    logic                       split_q;

    logic [2:0]                 opcode;
    logic [2:0]                 eff_op;
    logic [CHARACTER_WIDTH-1:0] ch;
    logic                       char_eq;
    logic [PC_WIDTH-1:0]        target;
    logic [PC_WIDTH-1:0]        pc_inc;
    logic [CC_ID_BITS-1:0]      cc_inc;
    logic                       unused_instr;

    assign opcode       = instr_q[MEMORY_WIDTH-1 -: 3];
    assign ch           = window_q[cc_q*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    assign char_eq      = (ch == instr_q[CHARACTER_WIDTH-1:0]);
    assign target       = instr_q[PC_WIDTH-1:0];
    assign pc_inc       = pc_q + 1'b1;
    assign cc_inc       = cc_q + 1'b1;
    assign unused_instr = ^instr_q;

    // Without the extension the two extra opcodes simply drop the thread.
    always_comb begin
        eff_op = opcode;
`ifndef REGEX_CPU_WINDOW_EXT_OPCODES_EN
        if (opcode == OP_MATCH_ANY || opcode == OP_NOT_MATCH)
            eff_op = OP_END;
`endif
    end

    assign input_pc_ready  = (state == S_IDLE);
    assign memory_valid    = (state == S_FETCH);
    assign output_pc_valid = (state == S_OUT_A) || (state == S_OUT_B);

    always_comb begin
        memory_addr                = '0;
        memory_addr[PC_WIDTH-1:0]  = pc_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            pc_q         <= '0;
            cc_q         <= '0;
            window_q     <= '0;
            instr_q      <= '0;
            split_q      <= 1'b0;
            output_pc    <= '0;
            output_cc_id <= '0;
            accepts      <= 1'b0;
        end else begin
            accepts <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (input_pc_valid) begin
                        pc_q     <= input_pc;
                        cc_q     <= input_cc_id;
                        window_q <= current_characters;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (memory_ready)
                        state <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    instr_q <= memory_data;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    split_q <= (eff_op == OP_SPLIT);
                    state   <= S_IDLE;
                    case (eff_op)
                        OP_ACCEPT:         accepts <= (ch == '0);
                        OP_ACCEPT_PARTIAL: accepts <= 1'b1;
                        OP_SPLIT: begin
                            output_pc    <= pc_inc;
                            output_cc_id <= cc_q;
                            state        <= S_OUT_A;
                        end
                        OP_JMP: begin
                            output_pc    <= target;
                            output_cc_id <= cc_q;
                            state        <= S_OUT_A;
                        end
                        OP_MATCH, OP_NOT_MATCH, OP_MATCH_ANY: begin
                            if ((eff_op == OP_MATCH_ANY) ||
                                (eff_op == OP_MATCH && char_eq) ||
                                (eff_op == OP_NOT_MATCH && !char_eq)) begin
                                output_pc    <= pc_inc;
                                output_cc_id <= cc_inc;
                                state        <= S_OUT_A;
                            end
                        end
                        default: ;
                    endcase
                end
                S_OUT_A: begin
                    if (output_pc_ready) begin
                        if (split_q) begin
                            output_pc <= target;
                            state     <= S_OUT_B;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_OUT_B: begin
                    if (output_pc_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regex_cpu_window.sv
// Directed bench for regex_cpu_window with a small instruction-memory model.
module tb_regex_cpu_window;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_characters;
    logic        input_pc_valid;
    logic        input_pc_ready;
    logic [7:0]  input_pc;
    logic [1:0]  input_cc_id;
    logic        memory_valid;
    logic        memory_ready;
    logic [10:0] memory_addr;
    logic [15:0] memory_data;
    logic        output_pc_valid;
    logic        output_pc_ready;
    logic [7:0]  output_pc;
    logic [1:0]  output_cc_id;
    logic        accepts;

    logic [15:0] mem [0:255];
    int total = 0;
    int bad   = 0;

    localparam logic [31:0] WIN_A = 32'h0063_6261;  // slot0=0x61 .. slot3=0x00
    localparam logic [31:0] WIN_B = 32'h4163_6261;  // slot3=0x41

    regex_cpu_window dut (
        .clk                (clk),
        .rst                (rst),
        .current_characters (current_characters),
        .input_pc_valid     (input_pc_valid),
        .input_pc_ready     (input_pc_ready),
        .input_pc           (input_pc),
        .input_cc_id        (input_cc_id),
        .memory_valid       (memory_valid),
        .memory_ready       (memory_ready),
        .memory_addr        (memory_addr),
        .memory_data        (memory_data),
        .output_pc_valid    (output_pc_valid),
        .output_pc_ready    (output_pc_ready),
        .output_pc          (output_pc),
        .output_cc_id       (output_cc_id),
        .accepts            (accepts)
    );

    always #5 clk = ~clk;

    // Data is only meaningful the cycle after a handshake; otherwise garbage (an ACCEPT_PARTIAL word).
    always @(posedge clk) begin
        if (memory_valid && memory_ready)
            memory_data <= mem[memory_addr[7:0]];
        else
            memory_data <= 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a thread while IDLE; returns sampling cycle 4 (first output cycle).
    task automatic launch(input logic [7:0] pc, input logic [1:0] cc, input logic [31:0] win);
        input_pc_valid     = 1'b1;
        input_pc           = pc;
        input_cc_id        = cc;
        current_characters = win;
        step();
        input_pc_valid     = 1'b0;
        current_characters = 32'hFFFF_FFFF;
        chk("fetch_vld", memory_valid, 1);
        chk("fetch_addr", memory_addr, {24'd0, pc});
        chk("busy_rdy", input_pc_ready, 0);
        step();
        chk("fetch_drop", memory_valid, 0);
        step();
        chk("exec_no_out", output_pc_valid, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
        mem[5]    = 16'h4061;  // MATCH 0x61
        mem[255]  = 16'h4000;  // MATCH 0x00
        mem[7]    = 16'h2040;  // SPLIT 0x40
        mem[9]    = 16'h0000;  // ACCEPT
        mem[10]   = 16'hC000;  // ACCEPT_PARTIAL
        mem[11]   = 16'h7234;  // JMP data 0x1234 -> pc 0x34
        mem[12]   = 16'hA000;  // MATCH_ANY
        mem[13]   = 16'hE061;  // NOT_MATCH 0x61

        rst                = 1'b0;
        input_pc_valid     = 1'b0;
        input_pc           = '0;
        input_cc_id        = '0;
        current_characters = '0;
        memory_ready       = 1'b1;
        output_pc_ready    = 1'b1;
        step();
        chk("rst_in_rdy", input_pc_ready, 1);
        chk("rst_mem_vld", memory_valid, 0);
        chk("rst_mem_addr", memory_addr, 0);
        chk("rst_out_vld", output_pc_valid, 0);
        chk("rst_out_pc", output_pc, 0);
        chk("rst_out_cc", output_cc_id, 0);
        chk("rst_acc", accepts, 0);
        rst = 1'b1;
        step();

        // MATCH hit
        launch(8'd5, 2'd0, WIN_A);
        chk("hit_vld", output_pc_valid, 1);
        chk("hit_pc", output_pc, 8'd6);
        chk("hit_cc", output_cc_id, 2'd1);
        chk("hit_rdy", input_pc_ready, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hit_idle_rdy", input_pc_ready, 1);
            chk("hit_idle_vld", output_pc_valid, 0);
        end

        // MATCH miss (slot3=0x00 vs 0x61)
        launch(8'd5, 2'd3, WIN_A);
        chk("miss_vld", output_pc_valid, 0);
        chk("miss_acc", accepts, 0);
        chk("miss_rdy", input_pc_ready, 1);
        step();

        // pc and cc_id wrap
        launch(8'hFF, 2'd3, WIN_A);
        chk("wrap_vld", output_pc_valid, 1);
        chk("wrap_pc", output_pc, 8'h00);
        chk("wrap_cc", output_cc_id, 2'd0);
        step();

        // SPLIT under backpressure
        output_pc_ready = 1'b0;
        launch(8'd7, 2'd2, WIN_A);
        for (int i = 0; i < 5; i++) begin
            chk("split_a_vld", output_pc_valid, 1);
            chk("split_a_pc", output_pc, 8'd8);
            chk("split_a_cc", output_cc_id, 2'd2);
            chk("split_a_rdy", input_pc_ready, 0);
            step();
        end
        output_pc_ready = 1'b1;
        step();
        chk("split_b_vld", output_pc_valid, 1);
        chk("split_b_pc", output_pc, 8'h40);
        chk("split_b_cc", output_cc_id, 2'd2);
        step();
        chk("split_end_vld", output_pc_valid, 0);
        chk("split_end_rdy", input_pc_ready, 1);

        // ACCEPT with slot3=0x00: single-cycle pulse
        launch(8'd9, 2'd3, WIN_A);
        chk("acc_pulse", accepts, 1);
        chk("acc_no_out", output_pc_valid, 0);
        step();
        chk("acc_pulse_end", accepts, 0);

        // ACCEPT with slot3=0x41: no pulse
        launch(8'd9, 2'd3, WIN_B);
        chk("acc_nz", accepts, 0);
        step();
        chk("acc_nz_after", accepts, 0);

        // ACCEPT_PARTIAL ignores the character
        launch(8'd10, 2'd3, WIN_B);
        chk("accp_pulse", accepts, 1);
        step();
        chk("accp_end", accepts, 0);

        // JMP target truncated to pc width
        launch(8'd11, 2'd1, WIN_A);
        chk("jmp_vld", output_pc_valid, 1);
        chk("jmp_pc", output_pc, 8'h34);
        chk("jmp_cc", output_cc_id, 2'd1);
        step();
        chk("jmp_done", input_pc_ready, 1);

        // Reset while waiting for instruction data
        input_pc_valid     = 1'b1;
        input_pc           = 8'd5;
        input_cc_id        = 2'd0;
        current_characters = WIN_A;
        step();
        input_pc_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy", input_pc_ready, 1);
        chk("mid_rst_mvld", memory_valid, 0);
        chk("mid_rst_ovld", output_pc_valid, 0);
        chk("mid_rst_opc", output_pc, 0);
        chk("mid_rst_acc", accepts, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_vld", output_pc_valid, 0);
            chk("post_rst_acc", accepts, 0);
            chk("post_rst_rdy", input_pc_ready, 1);
        end

        // Extension opcodes
        launch(8'd12, 2'd3, WIN_A);
`ifdef REGEX_CPU_WINDOW_EXT_OPCODES_EN
        chk("many_vld", output_pc_valid, 1);
        chk("many_pc", output_pc, 8'd13);
        chk("many_cc", output_cc_id, 2'd0);
`else
        chk("many_vld", output_pc_valid, 0);
        chk("many_acc", accepts, 0);
`endif
        step();
        launch(8'd13, 2'd1, WIN_A);
`ifdef REGEX_CPU_WINDOW_EXT_OPCODES_EN
        chk("nmatch_vld", output_pc_valid, 1);
        chk("nmatch_pc", output_pc, 8'd14);
        chk("nmatch_cc", output_cc_id, 2'd2);
`else
        chk("nmatch_vld", output_pc_valid, 0);
        chk("nmatch_acc", accepts, 0);
`endif
        step();
        chk("final_rdy", input_pc_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regex_cpu_window.md
# regex_cpu_window

- Single-thread regex execution unit; successor to `regex_cpu`.
- Accepts one (pc, cc_id) thread, fetches its instruction from instruction memory and executes it against one character of a multi-character window. Emits zero, one or two successor threads.
- Sits between the thread arbiter/FIFOs and the shared instruction-memory port.
- New over `regex_cpu`: window of 2**CC_ID_BITS characters, SPLIT with two sequential outputs, and JMP/ACCEPT_PARTIAL/END opcodes.

## Interface
- PC_WIDTH, 8, thread pc width; must be ≤ MEMORY_ADDR_WIDTH.
- CHARACTER_WIDTH, 8, character width.
- CC_ID_BITS, 2, window index width; window = 2**CC_ID_BITS characters.
- MEMORY_WIDTH, 16, instruction width: opcode = bits [MEMORY_WIDTH-1 -: 3], data = bits [MEMORY_WIDTH-4:0].
- MEMORY_ADDR_WIDTH, 11, instruction address width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-low.
- current_characters  in  (2**CC_ID_BITS)*CHARACTER_WIDTH  window; slot i at bits [i*CHARACTER_WIDTH +: CHARACTER_WIDTH].
- input_pc_valid / input_pc_ready  in / out  1  thread-input handshake.
- input_pc  in  PC_WIDTH  thread pc.
- input_cc_id  in  CC_ID_BITS  window slot this thread consumes.
- memory_valid / memory_ready  out / in  1  fetch request handshake.
- memory_addr  out  MEMORY_ADDR_WIDTH  fetch address.
- memory_data  in  MEMORY_WIDTH  instruction; valid the cycle after the fetch handshake.
- output_pc_valid / output_pc_ready  out / in  1  thread-output handshake.
- output_pc  out  PC_WIDTH  successor pc.
- output_cc_id  out  CC_ID_BITS  successor window slot.
- accepts  out  1  one-cycle accept pulse.

## Operation
- States: IDLE, FETCH, WAIT_DATA, EXEC, OUT_A, OUT_B.
- IDLE
  - input_pc_ready=1.
  - On valid&ready: latch pc, cc_id and the whole window into registers; go to FETCH.
- FETCH
  - memory_valid=1; memory_addr = zero-extended pc.
  - On memory_ready: go to WAIT_DATA.
- WAIT_DATA
  - Register memory_data; go to EXEC.
- EXEC: ch = latched window[cc_id]; decode opcode:
  - 0 ACCEPT: if ch==0, pulse accepts. Go to IDLE.
  - 1 SPLIT: OUT_A with (pc+1, cc_id), then OUT_B with (data, cc_id).
  - 2 MATCH: if ch==data[CHARACTER_WIDTH-1:0], go to OUT_A with (pc+1, cc_id+1); else go to IDLE.
  - 3 JMP: OUT_A with (data, cc_id).
  - 4 END_WITHOUT_ACCEPTING: go to IDLE.
  - 5 MATCH_ANY: OUT_A with (pc+1, cc_id+1).
  - 6 ACCEPT_PARTIAL: pulse accepts unconditionally. Go to IDLE.
  - 7 NOT_MATCH: inverse condition of MATCH; same outputs.
- OUT_A / OUT_B
  - output_pc_valid=1; hold pc and cc_id stable until ready.
  - On handshake: OUT_A goes to OUT_B if SPLIT, else to IDLE; OUT_B goes to IDLE.
- Arithmetic
  - pc+1 wraps modulo 2**PC_WIDTH.
  - cc_id+1 wraps modulo 2**CC_ID_BITS.
  - Jump/split targets = data truncated to PC_WIDTH.

## Timing
- Reset values: all outputs 0, except input_pc_ready=1 (IDLE).
- Reset during any state aborts the thread. A memory_data arriving after reset is ignored.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- Latency with memory_ready and output_pc_ready tied high, acceptance at edge E0:
  - memory_valid high in cycle 1 (handshake at E1).
  - Data sampled at E2.
  - EXEC in cycle 3.
  - output_pc_valid from cycle 4.
  - SPLIT: second output in cycle 5.
  - accepts pulses in cycle 4.
- input_pc_ready=0 from the cycle after acceptance until IDLE is re-entered.
- input_pc_ready and output_pc_valid are never high together.
- memory_valid deasserts the cycle after its handshake.
- Backpressure: output_pc_valid, output_pc and output_cc_id stay constant while output_pc_ready=0, indefinitely.
- Reserved encodings: none; all 8 opcodes are defined.

## Configuration
- REGEX_CPU_WINDOW_EXT_OPCODES_EN
  - Defined: MATCH_ANY (5) and NOT_MATCH (7) execute as above.
  - Undefined: both decode as END_WITHOUT_ACCEPTING; thread dropped, no output, no accept.
  - All other opcodes are unaffected.

## Test plan
- MATCH hit: window {0x00,0x63,0x62,0x61} (slot0=0x61), pc=5, cc_id=0, mem[5]={MATCH,0x61} → memory_addr=5, output (6, cc_id 1) in cycle 4, then 10 idle cycles with input_pc_ready=1.
- MATCH miss and wrap: same window, cc_id=3, mem={MATCH,0x61} → no output, no accept. Then pc=0xFF, cc_id=3, data 0x00 → output (0x00, cc_id 0).
- SPLIT under backpressure: mem[7]={SPLIT,0x40}, output_pc_ready low for 5 cycles → (8,cc_id) held stable, then (0x40,cc_id), then IDLE.
- ACCEPT: cc_id=3 with slot3=0x00 → accepts pulse exactly 1 cycle. Slot3=0x41 → no pulse. ACCEPT_PARTIAL → pulse regardless.
- Reset mid-operation: assert rst=0 in WAIT_DATA → next cycle all outputs 0, input_pc_ready=1; a late memory_data produces nothing.
- Macro off: mem={MATCH_ANY,x} → no output; macro on → output (pc+1, cc_id+1).
